// File: rtl/register_set_sb.sv
// register_set_sb: parametrised register set with two combinational read
// ports, one write port and a pending-write scoreboard.
// Register 0 is hardwired to zero. Indices >= NUM_REGS read as zero and
// not busy; writes and issues to them are ignored.
// Optional feature: define REGSET_BYPASS_EN to forward same-cycle write
// data to a read port whose index matches the write index.
module register_set_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rnum1,
    input  logic [ADDR_W-1:0] rnum2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              write,
    input  logic [ADDR_W-1:0] wnum,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue,
    input  logic [ADDR_W-1:0] inum,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);

    // One extra bit so NUM_REGS itself is representable in the comparison.
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;

    logic wr_ok;
    logic is_ok;

    // A write or issue only counts when it targets a real, non-zero register.
    always_comb begin
        wr_ok = write && (wnum != '0) && ({1'b0, wnum} < NUM_REGS_W);
        is_ok = issue && (inum != '0) && ({1'b0, inum} < NUM_REGS_W);
    end

    // Next register contents: only the addressed register takes wdata.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        regs_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (wr_ok && (wnum == ADDR_W'(r))) begin
                regs_d[r] = wdata;
            end
        end
    end

    // Next pending bits: flush beats issue, issue beats writeback clear.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (is_ok && (inum == ADDR_W'(r))) begin
                    pend_d[r] = 1'b1;
                end else if (wr_ok && (wnum == ADDR_W'(r))) begin
                    pend_d[r] = 1'b0;
                end
            end
        end
        pend_d[0] = 1'b0;
    end

    // Population count of the next pending bits, so the registered count
    // always matches the registered bits.
    always_comb begin
        cnt_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: a one-hot mux over registers 1..NUM_REGS-1, so index 0
    // and out-of-range indices fall through to zero / not busy.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        rbusy1 = 1'b0;
        rbusy2 = 1'b0;
        if (!rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (rnum1 == ADDR_W'(r)) begin
                    rdata1 = regs_q[r];
                    rbusy1 = pend_q[r];
                end
                if (rnum2 == ADDR_W'(r)) begin
                    rdata2 = regs_q[r];
                    rbusy2 = pend_q[r];
                end
            end
`ifdef REGSET_BYPASS_EN
            // Write-through: the in-flight write data wins over the stored
            // value. Busy flags are unaffected.
            if (wr_ok && (rnum1 == wnum)) begin
                rdata1 = wdata;
            end
            if (wr_ok && (rnum2 == wnum)) begin
                rdata2 = wdata;
            end
`endif
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_register_set_sb.sv
// Testbench for register_set_sb: directed vector table, hand-written
// scoreboard-fill/flush sequence, then randomized traffic checked against
// a behavioural model. Honours REGSET_BYPASS_EN the same way as the design.
module tb_register_set_sb;

`ifdef REGSET_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  rnum1, rnum2;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic        write;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        issue;
    logic [4:0]  inum;
    logic        flush;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    register_set_sb #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rnum1(rnum1), .rnum2(rnum2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .write(write), .wnum(wnum), .wdata(wdata),
        .issue(issue), .inum(inum), .flush(flush),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: architectural contents plus set of pending regs.
    logic [31:0] m_mem [32];
    bit          m_pend [32];

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (write && wnum != 0) m_mem[wnum] = wdata;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else begin
                if (write && wnum != 0) m_pend[wnum] = 1'b0;
                if (issue && inum != 0) m_pend[inum] = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] n);
        if (rst) return '0;
        if (BYP && write && wnum != 0 && n == wnum) return wdata;
        return (n == 0) ? 32'h0 : m_mem[n];
    endfunction

    function automatic logic model_busy(input logic [4:0] n);
        if (rst || n == 0) return 1'b0;
        return m_pend[n];
    endfunction

    function automatic logic [5:0] model_cnt();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(m_pend[i]);
        return 6'(c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic b1, input logic b2, input logic [5:0] ec);
        chk({tag, ".rdata1"}, rdata1, e1);
        chk({tag, ".rdata2"}, rdata2, e2);
        chk({tag, ".rbusy1"}, {31'b0, rbusy1}, {31'b0, b1});
        chk({tag, ".rbusy2"}, {31'b0, rbusy2}, {31'b0, b2});
        chk({tag, ".pend_cnt"}, {26'b0, pend_cnt}, {26'b0, ec});
    endtask

    // Advance one clock edge, keeping the model in step with the DUT.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; write = 0; wnum = 0; wdata = 0; issue = 0; inum = 0; flush = 0;
    endtask

    typedef struct {
        logic        rst, write;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        issue;
        logic [4:0]  inum;
        logic        flush;
        logic [4:0]  rnum1, rnum2;
        logic [31:0] e_rd1, e_rd2;
        logic        e_rb1, e_rb2;
        logic [5:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic w, logic [4:0] wn, logic [31:0] wd,
                                logic is, logic [4:0] in, logic fl,
                                logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] d1, logic [31:0] d2,
                                logic b1, logic b2, logic [5:0] c);
        vec_t v;
        v.rst = r; v.write = w; v.wnum = wn; v.wdata = wd;
        v.issue = is; v.inum = in; v.flush = fl;
        v.rnum1 = r1; v.rnum2 = r2;
        v.e_rd1 = d1; v.e_rd2 = d2; v.e_rb1 = b1; v.e_rb2 = b2; v.e_cnt = c;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        // Each row: inputs held for one cycle, outputs checked before the edge.
        //          rst w  wn  wdata         is in fl r1 r2  rd1                         rd2                   b1 b2 cnt
        tbl[0]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 5, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[1]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0,                0, 0, 0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 5, 0,  32'hDEADBEEF,               32'h0,                0, 0, 0);
        tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0, 0, 5, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[4]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 5, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[5]  = mk(0, 1, 0,  32'h12345678, 0, 0, 0, 0, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        1, 0, 0, 0, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[7]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 0, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[8]  = mk(0, 1, 7,  32'hA5A5A5A5, 0, 0, 0, 7, 0,  BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0,                0, 0, 0);
        tbl[9]  = mk(0, 0, 0,  32'h0,        0, 0, 0, 7, 0,  32'hA5A5A5A5,               32'h0,                0, 0, 0);
        tbl[10] = mk(0, 0, 0,  32'h0,        1, 3, 0, 3, 0,  32'h0,                      32'h0,                0, 0, 0);
        tbl[11] = mk(0, 0, 0,  32'h0,        1, 9, 0, 3, 9,  32'h0,                      32'h0,                1, 0, 1);
        tbl[12] = mk(0, 1, 3,  32'h33,       0, 0, 0, 3, 9,  BYP ? 32'h33 : 32'h0,       32'h0,                1, 1, 2);
        tbl[13] = mk(0, 0, 0,  32'h0,        0, 0, 0, 3, 9,  32'h33,                     32'h0,                0, 1, 1);
        tbl[14] = mk(0, 1, 4,  32'h44,       1, 4, 0, 4, 9,  BYP ? 32'h44 : 32'h0,       32'h0,                0, 1, 1);
        tbl[15] = mk(0, 1, 9,  32'h99,       1, 6, 0, 4, 9,  32'h44,                     BYP ? 32'h99 : 32'h0, 1, 1, 2);
        tbl[16] = mk(0, 0, 0,  32'h0,        0, 0, 0, 6, 9,  32'h0,                      32'h99,               1, 0, 2);

        model_reset();
        idle();
        rst = 1; rnum1 = 0; rnum2 = 0;
        step();
        step();

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; write = tbl[i].write; wnum = tbl[i].wnum; wdata = tbl[i].wdata;
            issue = tbl[i].issue; inum = tbl[i].inum; flush = tbl[i].flush;
            rnum1 = tbl[i].rnum1; rnum2 = tbl[i].rnum2;
            @(negedge clk);
            $display("vec %0d: rd1=%08h rd2=%08h b1=%0b b2=%0b cnt=%0d",
                     i, rdata1, rdata2, rbusy1, rbusy2, pend_cnt);
            chk_all($sformatf("vec%0d", i), tbl[i].e_rd1, tbl[i].e_rd2,
                    tbl[i].e_rb1, tbl[i].e_rb2, tbl[i].e_cnt);
            step();
        end

        // Fill the scoreboard one register per cycle.
        idle();
        for (int i = 1; i < 32; i++) begin
            issue = 1; inum = 5'(i);
            step();
        end
        idle();
        rnum1 = 17; rnum2 = 31;
        @(negedge clk);
        $display("fill: cnt=%0d b1=%0b b2=%0b", pend_cnt, rbusy1, rbusy2);
        chk("fill.pend_cnt", {26'b0, pend_cnt}, 32'd31);
        chk("fill.rbusy1", {31'b0, rbusy1}, 32'd1);
        chk("fill.rbusy2", {31'b0, rbusy2}, 32'd1);

        // Flush wins over a simultaneous issue.
        flush = 1; issue = 1; inum = 2; rnum1 = 2;
        step();
        idle();
        @(negedge clk);
        $display("flush: cnt=%0d b1=%0b", pend_cnt, rbusy1);
        chk("flush.pend_cnt", {26'b0, pend_cnt}, 32'd0);
        chk("flush.rbusy1", {31'b0, rbusy1}, 32'd0);
        chk("flush.rbusy2", {31'b0, rbusy2}, 32'd0);

        issue = 1; inum = 2;
        step();
        idle();
        @(negedge clk);
        $display("reissue: cnt=%0d b1=%0b", pend_cnt, rbusy1);
        chk("reissue.pend_cnt", {26'b0, pend_cnt}, 32'd1);
        chk("reissue.rbusy1", {31'b0, rbusy1}, 32'd1);

        // Randomized traffic against the model.
        for (int t = 0; t < 500; t++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 24) == 0);
            write = $urandom_range(0, 1);
            issue = $urandom_range(0, 1);
            wnum  = 5'($urandom_range(0, 31));
            inum  = ($urandom_range(0, 3) == 0) ? wnum : 5'($urandom_range(0, 31));
            wdata = $urandom;
            rnum1 = ($urandom_range(0, 3) == 0) ? wnum : 5'($urandom_range(0, 31));
            rnum2 = 5'($urandom_range(0, 31));
            @(negedge clk);
            $display("rand %0d: r1=%0d rd1=%08h r2=%0d rd2=%08h b=%0b%0b cnt=%0d",
                     t, rnum1, rdata1, rnum2, rdata2, rbusy1, rbusy2, pend_cnt);
            chk_all($sformatf("rand%0d", t), model_rd(rnum1), model_rd(rnum2),
                    model_busy(rnum1), model_busy(rnum2), model_cnt());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_set_sb.md
Name: register_set_sb

Overview:
- Parametrised successor to the processor's 32x32 register set: configurable data width and register count.
- Two combinational read ports and one write port. Register 0 is hardwired to zero.
- Adds a pending-write scoreboard: the decode stage marks a destination busy at issue; writeback clears it. Hazard logic reads per-port busy flags and a pending-write counter.
- Sits between the decode and writeback stages of the MIPS pipeline.

Parameters:
- DATA_W, 32, register data width in bits
- NUM_REGS, 32, number of architectural registers (2..32)
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rnum1  input  ADDR_W  read port 1 register index
- rnum2  input  ADDR_W  read port 2 register index
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data
- rbusy1  output  1  register rnum1 has a pending write
- rbusy2  output  1  register rnum2 has a pending write
- write  input  1  writeback strobe
- wnum  input  ADDR_W  writeback register index
- wdata  input  DATA_W  writeback data
- issue  input  1  mark register inum pending
- inum  input  ADDR_W  issued destination index
- flush  input  1  clear all pending bits (pipeline flush)
- pend_cnt  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: rst sampled on clk rising edge. All registers clear to 0, all pending bits clear, pend_cnt=0.
- While rst is high, rdata1, rdata2, rbusy1 and rbusy2 are forced to 0 combinationally.
- Reads are combinational, with zero latency.
  - Index 0 always reads 0 and never reads busy.
  - Index >= NUM_REGS reads 0 and not busy.
- Write: when write=1 and 0<wnum<NUM_REGS, register wnum takes wdata at the clock edge. The new value is visible on the next cycle; see the bypass option for same-cycle visibility.
  - Writes to index 0 or out-of-range indices are ignored.
- Pending bits, per register r != 0, at the edge:
  - flush=1: bit clears. flush overrides issue and write.
  - else issue=1 and inum==r: bit sets. Issue wins over a simultaneous write to the same r.
  - else write=1 and wnum==r: bit clears.
  - else bit holds.
  - Issue to index 0 or out-of-range indices is ignored.
  - Issue to an already-pending register leaves it pending; there is no nesting or count.
- rbusy1/rbusy2 reflect the registered pending bits only. A same-cycle issue does not show until the next cycle.
- pend_cnt: registered population count of the pending bits.
  - Updated in the same edge as the bits, so it is always consistent with them.
  - Maximum value NUM_REGS-1.
- Simultaneous issue and write to different registers in one cycle: both take effect.

Optional Feature:
- Macro REGSET_BYPASS_EN.
- Defined: write-through bypass. When write=1, wnum!=0, wnum<NUM_REGS and rnumN==wnum, rdataN=wdata in the same cycle. The bypass is suppressed while rst=1.
- Undefined: the read returns the stored (old) value until the next cycle.
- The bypass does not affect rbusyN.

Test Plan:
- Reset, then write reg 5 = 0xDEADBEEF. Next cycle rnum1=5 -> rdata1=0xDEADBEEF. Assert rst for one cycle -> rdata1=0; after release rdata1=0.
- write=1, wnum=0, wdata=0x12345678, then rnum2=0 -> rdata2=0. issue inum=0 -> rbusy2=0, pend_cnt=0.
- Bypass: write reg 7 = 0xA5A5A5A5 with rnum1=7 in the same cycle.
  - With REGSET_BYPASS_EN: rdata1=0xA5A5A5A5 that cycle.
  - Without it: rdata1=old value (0), then 0xA5A5A5A5 next cycle.
- Scoreboard sequence:
  - issue inum=3 -> next cycle rbusy1(rnum1=3)=1, pend_cnt=1.
  - issue 9 -> pend_cnt=2.
  - write 3 -> rbusy1=0, pend_cnt=1.
- Simultaneous issue and write:
  - issue inum=4 and write wnum=4 in one cycle -> reg 4 pending and written, pend_cnt+1.
  - issue 6 with write 9 (9 pending) -> 6 busy, 9 clear, pend_cnt unchanged.
- Issue regs 1..31 over 31 cycles -> pend_cnt=31. Then flush together with issue 2 -> all bits clear, pend_cnt=0. Next issue 2 -> pend_cnt=1.
